// File: rtl/phys_reg_free_list.sv
// Physical register free list: a circular FIFO of free tags with a speculative
// head, a commit head and a tail, so a flush can roll back uncommitted allocations.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 256,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             AllocReq,
  output logic             AllocGrant,
  output logic [TAG_W-1:0] AllocTag,
  input  logic             RelValid,
  input  logic [TAG_W-1:0] RelTag,
  input  logic             CommitValid,
  input  logic             Flush,
  output logic [TAG_W:0]   FreeCount,
  output logic             Empty,
  output logic             PrfInval,
  output logic [TAG_W-1:0] PrfInvalAddr,
  output logic             Error
);

  localparam int               NUM_FREE = NUM_PREGS - NUM_AREGS;
  localparam logic [TAG_W:0]   FREE_MAX = (TAG_W+1)'(NUM_FREE);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_PREGS - 1);

  // Pointer advance; the top bit is a wrap flag toggled when the index rolls over.
  function automatic logic [TAG_W:0] ptr_inc(input logic [TAG_W:0] ptr);
    logic [TAG_W:0] nxt;
    if (ptr[TAG_W-1:0] == LAST_IDX) begin
      nxt = {~ptr[TAG_W], {TAG_W{1'b0}}};
    end else begin
      nxt = ptr + {{TAG_W{1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  logic [TAG_W-1:0] r_mem [NUM_PREGS];
  logic [TAG_W:0]   r_spec_head;
  logic [TAG_W:0]   r_commit_head;
  logic [TAG_W:0]   r_tail;
  logic             r_error;

  logic [TAG_W:0]   w_free_count;
  logic             w_empty;
  logic             w_alloc_grant;
  logic             w_rel_err;
  logic             w_rel_ok;
  logic             w_commit_err;
  logic             w_commit_ok;
  logic [TAG_W:0]   w_commit_head_nxt;
  logic [TAG_W:0]   w_spec_head_nxt;
  logic [TAG_W:0]   w_tail_nxt;

  // Grant/violation decode and next-pointer selection from the registered state.
  always_comb begin
    w_free_count      = r_tail - r_spec_head;
    w_empty           = (w_free_count == {(TAG_W+1){1'b0}});
    w_alloc_grant     = AllocReq & ~w_empty & ~Flush & ~Reset;
    w_rel_err         = RelValid & (w_free_count == FREE_MAX);
    w_rel_ok          = RelValid & ~w_rel_err;
    w_commit_err      = CommitValid & (r_commit_head == r_spec_head);
    w_commit_ok       = CommitValid & ~w_commit_err;
    w_commit_head_nxt = w_commit_ok ? ptr_inc(r_commit_head) : r_commit_head;
    w_tail_nxt        = w_rel_ok ? ptr_inc(r_tail) : r_tail;
    // A flush rewinds to the commit head including this cycle's commit.
    if (Flush) begin
      w_spec_head_nxt = w_commit_head_nxt;
    end else if (w_alloc_grant) begin
      w_spec_head_nxt = ptr_inc(r_spec_head);
    end else begin
      w_spec_head_nxt = r_spec_head;
    end
  end

  // Storage, pointers and sticky error; reset preloads the non-architectural tags.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_mem[i] <= (i < NUM_FREE) ? TAG_W'(NUM_AREGS + i) : {TAG_W{1'b0}};
      end
      r_spec_head   <= {(TAG_W+1){1'b0}};
      r_commit_head <= {(TAG_W+1){1'b0}};
      r_tail        <= FREE_MAX;
      r_error       <= 1'b0;
    end else begin
      if (w_rel_ok) begin
        r_mem[r_tail[TAG_W-1:0]] <= RelTag;
      end
      r_spec_head   <= w_spec_head_nxt;
      r_commit_head <= w_commit_head_nxt;
      r_tail        <= w_tail_nxt;
      r_error       <= r_error | w_rel_err | w_commit_err;
    end
  end

  assign FreeCount    = w_free_count;
  assign Empty        = w_empty;
  assign AllocGrant   = w_alloc_grant;
  assign AllocTag     = r_mem[r_spec_head[TAG_W-1:0]];
  assign PrfInval     = w_alloc_grant;
  assign PrfInvalAddr = r_mem[r_spec_head[TAG_W-1:0]];
  assign Error        = r_error;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: a queue model of free tags and of
// speculatively allocated tags predicts every grant, tag, count and error.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       AllocReq;
  logic       AllocGrant;
  logic [7:0] AllocTag;
  logic       RelValid;
  logic [7:0] RelTag;
  logic       CommitValid;
  logic       Flush;
  logic [8:0] FreeCount;
  logic       Empty;
  logic       PrfInval;
  logic [7:0] PrfInvalAddr;
  logic       Error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] free_q[$];
  logic [7:0] spec_q[$];
  logic       model_err;

  phys_reg_free_list #(.NUM_PREGS(256), .NUM_AREGS(32), .TAG_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .AllocReq(AllocReq), .AllocGrant(AllocGrant),
    .AllocTag(AllocTag), .RelValid(RelValid), .RelTag(RelTag),
    .CommitValid(CommitValid), .Flush(Flush), .FreeCount(FreeCount),
    .Empty(Empty), .PrfInval(PrfInval), .PrfInvalAddr(PrfInvalAddr), .Error(Error)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    for (int i = 32; i < 256; i++) free_q.push_back(8'(i));
    model_err = 1'b0;
  endtask

  // One cycle of stimulus; outputs checked against the model before the edge.
  task automatic step(input logic req, input logic rel, input logic [7:0] rtag,
                      input logic cmt, input logic fl,
                      output logic g, output logic [7:0] tag);
    int  f0, s0;
    logic exp_grant;
    AllocReq = req; RelValid = rel; RelTag = rtag; CommitValid = cmt; Flush = fl;
    @(negedge CLK);
    f0 = free_q.size();
    s0 = spec_q.size();
    exp_grant = req && (f0 != 0) && !fl;
    g = AllocGrant;
    tag = AllocTag;
    checks++;
    if (AllocGrant !== exp_grant) begin
      failures++; $display("FAIL grant got=%0b exp=%0b", AllocGrant, exp_grant);
    end
    checks++;
    if (PrfInval !== exp_grant) begin
      failures++; $display("FAIL prf_inval got=%0b exp=%0b", PrfInval, exp_grant);
    end
    checks++;
    if (FreeCount !== 9'(f0)) begin
      failures++; $display("FAIL free_count got=%0d exp=%0d", FreeCount, f0);
    end
    checks++;
    if (Empty !== (f0 == 0)) begin
      failures++; $display("FAIL empty got=%0b exp=%0b", Empty, (f0 == 0));
    end
    checks++;
    if (Error !== model_err) begin
      failures++; $display("FAIL error got=%0b exp=%0b", Error, model_err);
    end
    if (f0 != 0) begin
      checks++;
      if (AllocTag !== free_q[0]) begin
        failures++; $display("FAIL alloc_tag got=%0d exp=%0d", AllocTag, free_q[0]);
      end
    end
    if (exp_grant) begin
      checks++;
      if (PrfInvalAddr !== free_q[0]) begin
        failures++; $display("FAIL prf_addr got=%0d exp=%0d", PrfInvalAddr, free_q[0]);
      end
    end
    if ((rel && f0 == 224) || (cmt && s0 == 0)) model_err = 1'b1;
    if (cmt && s0 != 0) void'(spec_q.pop_front());
    if (exp_grant) spec_q.push_back(free_q.pop_front());
    if (rel && f0 != 224) free_q.push_back(rtag);
    if (fl) begin
      free_q = {spec_q, free_q};
      spec_q.delete();
    end
    @(posedge CLK); #1;
    AllocReq = 1'b0; RelValid = 1'b0; CommitValid = 1'b0; Flush = 1'b0;
  endtask

  task automatic do_reset(input logic req);
    Reset = 1'b1; AllocReq = req; RelValid = 1'b1; RelTag = 8'd3;
    CommitValid = 1'b1; Flush = 1'b0;
    @(negedge CLK);
    checks++;
    if (AllocGrant !== 1'b0 || PrfInval !== 1'b0) begin
      failures++; $display("FAIL reset_grant got=%0b/%0b exp=0/0", AllocGrant, PrfInval);
    end
    @(posedge CLK); #1;
    Reset = 1'b0; AllocReq = 1'b0; RelValid = 1'b0; CommitValid = 1'b0; Flush = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (FreeCount !== 9'd224 || Empty !== 1'b0 || AllocTag !== 8'd32 ||
        AllocGrant !== 1'b0 || PrfInval !== 1'b0 || Error !== 1'b0) begin
      failures++;
      $display("FAIL %s got fc=%0d e=%0b tag=%0d g=%0b pi=%0b err=%0b exp 224/0/32/0/0/0",
               name, FreeCount, Empty, AllocTag, AllocGrant, PrfInval, Error);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    check_reset_state("reset_state");
  endtask

  task automatic test_post_reset_alloc();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
      checks++;
      if (g !== 1'b1 || t !== 8'(32 + k)) begin
        failures++; $display("FAIL post_reset_tag got=%0b/%0d exp=1/%0d", g, t, 32 + k);
      end
    end
    checks++;
    if (FreeCount !== 9'd221) begin
      failures++; $display("FAIL post_reset_count got=%0d exp=221", FreeCount);
    end
  endtask

  task automatic test_drain();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    for (int k = 0; k < 224; k++) step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
    checks++;
    if (Empty !== 1'b1 || FreeCount !== 9'd0) begin
      failures++; $display("FAIL drain_empty got=%0b/%0d exp=1/0", Empty, FreeCount);
    end
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, g, t);
    checks++;
    if (g !== 1'b0) begin
      failures++; $display("FAIL empty_no_bypass got=%0b exp=0", g);
    end
    checks++;
    if (AllocTag !== 8'd5 || Empty !== 1'b0) begin
      failures++; $display("FAIL released_tag got=%0d/%0b exp=5/0", AllocTag, Empty);
    end
  endtask

  task automatic test_flush();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, g, t);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, g, t);
    checks++;
    if (AllocTag !== 8'd36 || FreeCount !== 9'd220) begin
      failures++; $display("FAIL flush_rollback got=%0d/%0d exp=36/220", AllocTag, FreeCount);
    end
  endtask

  task automatic test_simultaneous();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    for (int k = 0; k < 124; k++) step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
    step(1'b1, 1'b1, 8'd7, 1'b1, 1'b0, g, t);
    checks++;
    if (g !== 1'b1 || FreeCount !== 9'd100) begin
      failures++; $display("FAIL simul got=%0b/%0d exp=1/100", g, FreeCount);
    end
    // Flush exposes the commit head: one committed tag leaves 224 free.
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, g, t);
    checks++;
    if (FreeCount !== 9'd224 || AllocTag !== 8'd33) begin
      failures++; $display("FAIL simul_commit got=%0d/%0d exp=224/33", FreeCount, AllocTag);
    end
  endtask

  task automatic test_errors();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, g, t);
    checks++;
    if (Error !== 1'b1 || FreeCount !== 9'd224) begin
      failures++; $display("FAIL rel_overflow got=%0b/%0d exp=1/224", Error, FreeCount);
    end
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
    do_reset(1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, g, t);
    checks++;
    if (Error !== 1'b1) begin
      failures++; $display("FAIL commit_underflow got=%0b exp=1", Error);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic g; logic [7:0] t;
    do_reset(1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, g, t);
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, g, t);
    end
    checks++;
    if (FreeCount !== 9'd223) begin
      failures++; $display("FAIL wrap_count got=%0d exp=223", FreeCount);
    end
    do_reset(1'b1);
    check_reset_state("midstream_reset");
  endtask

  initial begin
    Reset = 1'b1; AllocReq = 1'b0; RelValid = 1'b0; RelTag = 8'd0;
    CommitValid = 1'b0; Flush = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    test_reset();
    test_post_reset_alloc();
    test_drain();
    test_flush();
    test_simultaneous();
    test_errors();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
